mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequencing controller and result holder for the multiply/divide unit in the E stage of the five-stage pipeline.
- Accepts the 4-bit MDU operation code produced by the control unit and the forwarded E-stage operands.
- Runs the multi-cycle mult/div timing, owns the HI/LO registers and drives MDU_out for mfhi/mflo.
- Raises a stall request toward the hazard unit while a D-stage MDU instruction would collide with an operation in flight.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu after issue (min 1)
- DIV_LAT, 10, busy cycles for div/divu after issue (min 1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- E_MDUOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 treated as none
- E_valid  input  1  E-stage instruction is real (not a bubble)
- E_A  input  32  forwarded rs value
- E_B  input  32  forwarded rt value
- D_mdu_use  input  1  D-stage instruction is md, mf or mt
- start  output  1  combinational; an op is being issued this cycle
- busy  output  1  registered; operation in flight
- stall_req  output  1  combinational stall request to the hazard unit
- MDU_out  output  32  HI for op 5, LO for op 6, otherwise 0
- HI  output  32  current HI register
- LO  output  32  current LO register

Behaviour:
- Reset (async, active-high):
  - busy=0, counter=0, HI=0, LO=0, pending result cleared.
  - Reset mid-operation abandons the operation; HI/LO stay 0.
- Issue:
  - start = E_valid & (E_MDUOp in 1..4) & !busy.
  - On that edge: capture E_A/E_B, compute the pending 64-bit result, load counter with MULT_LAT or DIV_LAT, set busy=1.
- Counting:
  - Each edge with busy=1 decrements counter.
  - On the edge where counter goes 1->0: commit pending to HI/LO and set busy=0.
  - busy is high for exactly LAT cycles following the issue cycle.
  - An op issued at edge n has its HI/LO visible after edge n+LAT.
  - Back-to-back issue is allowed on the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32->64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: same, unsigned.
  - Divide by zero (div or divu): HI/LO unchanged at commit; the busy timing still runs the full DIV_LAT.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo (ops 7, 8):
  - When E_valid & !busy: HI (resp. LO) <= E_A at the edge, single cycle, no busy.
  - When busy=1: ignored. The stall logic prevents this case; the bench flags it as an error.
- mfhi/mflo (ops 5, 6): MDU_out is combinational from the current HI/LO. A read during busy returns the old value (prevented by stall).
- Stall: stall_req = D_mdu_use & (start | busy).
- Ops 0 and 9..15, or E_valid=0: no state change, start=0.
- Simultaneous commit and new issue on the same edge cannot occur, because issue requires busy=0.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- When defined:
  - Adds input port cancel (1 bit, exception/flush from the M stage).
  - cancel=1 with start=1 suppresses the issue: no state change, start forced to 0.
  - cancel=1 while busy aborts the op: busy=0 and counter=0 on the next edge, HI/LO keep their pre-issue values.
  - cancel on the commit edge wins; no commit.
  - cancel also blocks mthi/mtlo writes that cycle.
- When undefined: no cancel port; every issued op always commits.

Test Plan:
1. Reset mid-op: issue div, assert reset at cycle 4 -> busy=0, HI=0, LO=0 immediately.
2. mult: E_A=0xFFFFFFFE (-2), E_B=3, op 1 -> start=1 one cycle; busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with op 2 -> HI=0x00000002, LO=0xFFFFFFFA.
3. div: E_A=0xFFFFFFF9 (-7), E_B=2, op 3 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=0x11, LO=0x22 -> HI/LO unchanged after 10 cycles.
4. Stall: D_mdu_use=1 during the issue cycle and the 5 busy cycles of a mult -> stall_req=1 for 6 cycles, 0 on the cycle busy drops; mflo then reads the new LO via MDU_out.
5. mthi E_A=0xDEADBEEF then mfhi next cycle -> MDU_out=0xDEADBEEF. E_valid=0 with op 8 -> LO unchanged.
6. MDU_CANCEL_EN: cancel at busy cycle 3 of a mult -> busy=0 next edge, HI/LO retain old values. cancel with start -> busy stays 0.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Handshake/bus bundle between the E-stage datapath and the MDU controller.
// With MDU_CANCEL_EN defined, the bundle also carries the M-stage cancel.
interface mdu_ctrl_if;
   logic [3:0]  E_MDUOp;
   logic        E_valid;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        D_mdu_use;
   logic        start;
   logic        busy;
   logic        stall_req;
   logic [31:0] MDU_out;
   logic [31:0] HI;
   logic [31:0] LO;
`ifdef MDU_CANCEL_EN
   logic        cancel;
`endif

   modport master (
      output E_MDUOp, E_valid, E_A, E_B, D_mdu_use,
`ifdef MDU_CANCEL_EN
      output cancel,
`endif
      input  start, busy, stall_req, MDU_out, HI, LO
   );

   modport slave (
      input  E_MDUOp, E_valid, E_A, E_B, D_mdu_use,
`ifdef MDU_CANCEL_EN
      input  cancel,
`endif
      output start, busy, stall_req, MDU_out, HI, LO
   );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: multi-cycle mult/div timing, HI/LO ownership, stall request.
// Optional MDU_CANCEL_EN adds an M-stage cancel that suppresses issue/aborts ops in flight.
module mdu_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_ctrl_if.slave  bus
);
   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
   localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);

   logic [CW-1:0] cnt;
   logic          busy_q;
   logic [31:0]   hi_q, lo_q;
   logic [63:0]   pend;
   logic          pend_we;

   logic        kill;
   logic        is_md, is_div, is_sdiv, start_w, mt_ok;
   logic [31:0] a, b, dn, dd, uq, ur, q, r;
   logic [63:0] res;
   logic        res_we;

`ifdef MDU_CANCEL_EN
   assign kill = bus.cancel;
`else
   assign kill = 1'b0;
`endif

   assign a = bus.E_A;
   assign b = bus.E_B;

   always_comb begin
      is_md   = (bus.E_MDUOp >= 4'd1) && (bus.E_MDUOp <= 4'd4);
      is_div  = (bus.E_MDUOp == 4'd3) || (bus.E_MDUOp == 4'd4);
      is_sdiv = (bus.E_MDUOp == 4'd3);
      start_w = bus.E_valid & is_md & ~busy_q & ~kill;
      mt_ok   = bus.E_valid & ~busy_q & ~kill;
   end

   // One unsigned divider serves both div and divu: signed div runs on magnitudes
   // and fixes signs afterwards, which also yields 0x80000000/-1 -> q=0x80000000, r=0.
   always_comb begin
      dn = (is_sdiv && a[31]) ? (32'd0 - a) : a;
      dd = (is_sdiv && b[31]) ? (32'd0 - b) : b;
      if (dd == 32'd0) begin
         uq = 32'd0;
         ur = 32'd0;
      end else begin
         uq = dn / dd;
         ur = dn % dd;
      end
      q = (is_sdiv && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
      r = (is_sdiv && a[31]) ? (32'd0 - ur) : ur;
   end

   always_comb begin
      res    = 64'd0;
      res_we = 1'b1;
      case (bus.E_MDUOp)
         4'd1:    res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         4'd2:    res = {32'd0, a} * {32'd0, b};
         4'd3,
         4'd4: begin
            res    = {r, q};
            res_we = (b != 32'd0);
         end
         default: res = 64'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q  <= 1'b0;
         cnt     <= '0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         pend    <= 64'd0;
         pend_we <= 1'b0;
      end else begin
         if (start_w) begin
            pend    <= res;
            pend_we <= res_we;
            cnt     <= is_div ? DIV_CNT : MULT_CNT;
            busy_q  <= 1'b1;
         end else if (busy_q) begin
            if (kill) begin
               busy_q <= 1'b0;
               cnt    <= '0;
            end else begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  busy_q <= 1'b0;
                  if (pend_we) begin
                     hi_q <= pend[63:32];
                     lo_q <= pend[31:0];
                  end
               end
            end
         end
         if (mt_ok && bus.E_MDUOp == 4'd7) hi_q <= bus.E_A;
         if (mt_ok && bus.E_MDUOp == 4'd8) lo_q <= bus.E_A;
      end
   end

   assign bus.start     = start_w;
   assign bus.busy      = busy_q;
   assign bus.stall_req = bus.D_mdu_use & (start_w | busy_q);
   assign bus.HI        = hi_q;
   assign bus.LO        = lo_q;
   assign bus.MDU_out   = (bus.E_MDUOp == 4'd5) ? hi_q :
                          (bus.E_MDUOp == 4'd6) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: cycle-level reference model plus literal spot checks.
module tb_mdu_ctrl;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic clk = 1'b0;
   logic reset;
   logic cancel;
   int   nchk = 0;
   int   nerr = 0;

   mdu_ctrl_if bus ();
`ifdef MDU_CANCEL_EN
   assign bus.cancel = cancel;
`endif

   mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic on wide integers: {write_enable, HI, LO}
   function automatic logic [64:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         4'd1: begin q = sa * sb; return {1'b1, q[63:0]}; end
         4'd2: begin p = ua * ub; return {1'b1, p}; end
         4'd3: begin
            if (b == 32'd0) return 65'd0;
            q = sa / sb;
            r = sa % sb;
            return {1'b1, r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return 65'd0;
            p = ua / ub;
            ub = ua % ub;
            return {1'b1, ub[31:0], p[31:0]};
         end
         default: return 65'd0;
      endcase
   endfunction

   function automatic logic is_md(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd4);
   endfunction

   // Model: an op in flight is described by the edge number at which it completes.
   int          cyc = 0;
   int          m_end = 0;
   logic        m_active = 1'b0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
   logic        m_we = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active <= 1'b0;
         m_hi     <= 32'd0;
         m_lo     <= 32'd0;
      end else begin
         cyc <= cyc + 1;
         if (m_active && cancel) begin
            m_active <= 1'b0;
         end else if (m_active && (cyc + 1 == m_end)) begin
            m_active <= 1'b0;
            if (m_we) begin
               m_hi <= m_phi;
               m_lo <= m_plo;
            end
         end else if (!m_active && bus.E_valid && is_md(bus.E_MDUOp) && !cancel) begin
            m_active <= 1'b1;
            m_end    <= cyc + 1 + ((bus.E_MDUOp >= 4'd3) ? DIV_LAT : MULT_LAT);
            {m_we, m_phi, m_plo} <= ref_calc(bus.E_MDUOp, bus.E_A, bus.E_B);
         end
         if (!m_active && bus.E_valid && !cancel && bus.E_MDUOp == 4'd7) m_hi <= bus.E_A;
         if (!m_active && bus.E_valid && !cancel && bus.E_MDUOp == 4'd8) m_lo <= bus.E_A;
      end
   end

   function automatic logic exp_start();
      return bus.E_valid && is_md(bus.E_MDUOp) && !m_active && !cancel;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         chk("start", {31'd0, bus.start}, {31'd0, exp_start()});
         chk("busy", {31'd0, bus.busy}, {31'd0, m_active});
         chk("stall_req", {31'd0, bus.stall_req},
             {31'd0, bus.D_mdu_use && (exp_start() || m_active)});
         chk("MDU_out", bus.MDU_out, (bus.E_MDUOp == 4'd5) ? m_hi :
                                      (bus.E_MDUOp == 4'd6) ? m_lo : 32'd0);
         chk("HI", bus.HI, m_hi);
         chk("LO", bus.LO, m_lo);
      end
   end

   task automatic cyc1();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.E_valid   = 1'b0;
      bus.E_MDUOp   = 4'd0;
      bus.E_A       = 32'd0;
      bus.E_B       = 32'd0;
      bus.D_mdu_use = 1'b0;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.E_valid = 1'b1;
      bus.E_MDUOp = op;
      bus.E_A     = a;
      bus.E_B     = b;
   endtask

   int nb, ns;
   logic last;

   initial begin
      reset  = 1'b1;
      cancel = 1'b0;
      idle();
      repeat (2) cyc1();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_HI", bus.HI, 32'd0);
      chk("rst_LO", bus.LO, 32'd0);
      reset = 1'b0;

      // reset abandons a div in flight
      drive(4'd3, 32'd100, 32'd7);
      cyc1();
      idle();
      repeat (3) cyc1();
      reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_HI", bus.HI, 32'd0);
      chk("midrst_LO", bus.LO, 32'd0);
      cyc1();
      reset = 1'b0;
      cyc1();

      // mult -2*3, then multu
      drive(4'd1, 32'hFFFFFFFE, 32'd3);
      #1 chk("mult_start", {31'd0, bus.start}, 32'd1);
      cyc1();
      idle();
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.busy) nb++;
         cyc1();
      end
      chk("mult_busy_cycles", nb, 32'd5);
      chk("mult_HI", bus.HI, 32'hFFFFFFFF);
      chk("mult_LO", bus.LO, 32'hFFFFFFFA);

      drive(4'd2, 32'hFFFFFFFE, 32'd3);
      cyc1();
      idle();
      repeat (6) cyc1();
      chk("multu_HI", bus.HI, 32'h00000002);
      chk("multu_LO", bus.LO, 32'hFFFFFFFA);

      // signed div -7/2
      drive(4'd3, 32'hFFFFFFF9, 32'd2);
      cyc1();
      idle();
      nb = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.busy) nb++;
         cyc1();
      end
      chk("div_busy_cycles", nb, 32'd10);
      chk("div_LO", bus.LO, 32'hFFFFFFFD);
      chk("div_HI", bus.HI, 32'hFFFFFFFF);

      // overflow corner
      drive(4'd3, 32'h80000000, 32'hFFFFFFFF);
      cyc1();
      idle();
      repeat (11) cyc1();
      chk("divov_LO", bus.LO, 32'h80000000);
      chk("divov_HI", bus.HI, 32'h00000000);

      // divu by zero keeps HI/LO
      drive(4'd7, 32'h11, 32'd0);
      cyc1();
      drive(4'd8, 32'h22, 32'd0);
      cyc1();
      drive(4'd4, 32'd7, 32'd0);
      cyc1();
      idle();
      nb = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.busy) nb++;
         cyc1();
      end
      chk("div0_busy_cycles", nb, 32'd10);
      chk("div0_HI", bus.HI, 32'h11);
      chk("div0_LO", bus.LO, 32'h22);

      // stall window across a mult, then mflo
      drive(4'd1, 32'd6, 32'd7);
      bus.D_mdu_use = 1'b1;
      #1;
      ns = bus.stall_req ? 1 : 0;
      cyc1();
      bus.E_valid = 1'b0;
      bus.E_MDUOp = 4'd0;
      last = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (bus.stall_req) ns++;
         last = bus.stall_req;
         cyc1();
      end
      chk("stall_cycles", ns, 32'd6);
      chk("stall_drop", {31'd0, last}, 32'd0);
      bus.D_mdu_use = 1'b0;
      drive(4'd6, 32'd0, 32'd0);
      #1 chk("mflo_out", bus.MDU_out, 32'h2A);
      cyc1();

      // mthi then mfhi; bubble mtlo ignored
      drive(4'd7, 32'hDEADBEEF, 32'd0);
      cyc1();
      drive(4'd5, 32'd0, 32'd0);
      #1 chk("mfhi_out", bus.MDU_out, 32'hDEADBEEF);
      cyc1();
      idle();
      bus.E_MDUOp = 4'd8;
      bus.E_A     = 32'h1234;
      cyc1();
      #1 chk("bubble_mtlo_LO", bus.LO, 32'h2A);
      idle();
      cyc1();

`ifdef MDU_CANCEL_EN
      drive(4'd7, 32'h55, 32'd0);
      cyc1();
      drive(4'd8, 32'h66, 32'd0);
      cyc1();
      drive(4'd1, 32'd5, 32'd5);
      cyc1();
      idle();
      repeat (2) cyc1();
      cancel = 1'b1;
      cyc1();
      cancel = 1'b0;
      #1;
      chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
      chk("cancel_HI", bus.HI, 32'h55);
      chk("cancel_LO", bus.LO, 32'h66);
      repeat (8) cyc1();
      chk("cancel_late_LO", bus.LO, 32'h66);
      drive(4'd1, 32'd5, 32'd5);
      cancel = 1'b1;
      #1 chk("cancel_start", {31'd0, bus.start}, 32'd0);
      cyc1();
      cancel = 1'b0;
      idle();
      #1 chk("cancel_issue_busy", {31'd0, bus.busy}, 32'd0);
      cyc1();
`endif

      repeat (2) cyc1();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
